uart_tx_scheduler: RTL and testbench

Shares the single UartTx transmitter between two requesters: the core's MMIO send path (write to 0xfffffff4) and the boot/DMA path (echo/ack bytes during program load). Core bytes are buffered in an internal FIFO so the core never stalls on a busy transmitter. DMA bytes go through a direct request/acknowledge handshake. The block owns the `tx_start`/`sdata` drive, sequences each byte through a start/busy handshake, and supplies the free-slot count that the MMIO read at 0xfffffff8 returns.

---
 rtl/uart_tx_scheduler.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UartTx transmitter between the core MMIO send path and the
//   boot/DMA echo path. Core bytes are queued in a small FIFO so the core
//   never stalls. DMA bytes use a req/ack handshake. Each byte is sequenced
//   through a start pulse and the transmitter's busy rise/fall.
//
// Ports
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   core_we/data    : core MMIO send strobe and byte (one byte per cycle)
//   dma_req/data    : DMA request, held with stable data until dma_ack
//   dma_ack         : one-cycle pulse when the DMA byte is taken
//   overflow_clr    : clears the sticky overflow flag
//   tx_start/sdata  : start pulse and byte presented to UartTx
//   tx_busy         : UartTx busy flag
//   free_slots      : FIFO_DEPTH - occupancy, zero-extended (MMIO read value)
//   overflow        : sticky flag, set when a core byte is dropped
module uart_tx_scheduler #(
  parameter int FIFO_DEPTH   = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_we,
  input  logic [7:0]  core_data,
  input  logic        dma_req,
  input  logic [7:0]  dma_data,
  output logic        dma_ack,
  input  logic        overflow_clr,
  output logic        tx_start,
  output logic [7:0]  sdata,
  input  logic        tx_busy,
  output logic [31:0] free_slots,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [AW:0]   DEPTH        = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;
  typedef enum logic {GRANT_FIFO = 1'b0, GRANT_DMA = 1'b1} grant_t;

  state_t        state;
  grant_t        last_grant;
  logic [TW-1:0] tout;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic grant_any;
  logic grant_dma;
  logic grant_fifo;

  // Request decode and round-robin arbitration. On a tie the requester that
  // was not granted last wins; the FIFO is granted only when DMA is not.
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == DEPTH);
    push       = core_we && !fifo_full;
    grant_any  = (state == IDLE) && !tx_busy && (!fifo_empty || dma_req);
    grant_dma  = grant_any && dma_req && (fifo_empty || last_grant == GRANT_FIFO);
    grant_fifo = grant_any && !grant_dma;
    pop        = grant_fifo;
  end

  // Occupancy only changes when exactly one of push/pop happens.
  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + (AW+1)'(1);
    else if (!push && pop)
      count_next = count - (AW+1)'(1);
  end

  // FIFO storage has no reset: reset discards contents by clearing pointers.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= core_data;
  end

  // Pointers, occupancy and the sticky overflow flag. A drop in the same
  // cycle as overflow_clr leaves the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      if (core_we && fifo_full)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

  // Transmit sequencer. tx_start and dma_ack are registered on the grant so
  // they are high for exactly the LAUNCH cycle. WAIT_HI gives up after
  // BUSY_TIMEOUT cycles in case the transmitter never shows busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tout       <= '0;
      tx_start   <= 1'b0;
      dma_ack    <= 1'b0;
      sdata      <= 8'h00;
      last_grant <= GRANT_FIFO;
    end else begin
      tx_start <= 1'b0;
      dma_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dma) begin
            sdata      <= dma_data;
            dma_ack    <= 1'b1;
            tx_start   <= 1'b1;
            last_grant <= GRANT_DMA;
            state      <= LAUNCH;
          end else if (grant_fifo) begin
            sdata      <= mem[rd_ptr];
            tx_start   <= 1'b1;
            last_grant <= GRANT_FIFO;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          tout  <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy)
            state <= WAIT_LO;
          else if (tout == TIMEOUT_LAST)
            state <= IDLE;
          else
            tout <= tout + TW'(1);
        end
        WAIT_LO: begin
          if (!tx_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign free_slots = 32'(DEPTH - count);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   Directed bench for uart_tx_scheduler (FIFO_DEPTH=16, BUSY_TIMEOUT=4).
//   A negedge monitor logs every tx_start with its byte, dma_ack and a cycle
//   stamp; a simple UartTx model raises tx_busy after a start for 10 cycles,
//   or tx_busy can be driven directly by the tests.
module tb_uart_tx_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        core_we = 1'b0;
  logic [7:0]  core_data = 8'h00;
  logic        dma_req = 1'b0;
  logic [7:0]  dma_data = 8'h00;
  logic        dma_ack;
  logic        overflow_clr = 1'b0;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        tx_busy;
  logic [31:0] free_slots;
  logic        overflow;

  logic        model_en = 1'b0;
  logic        busy_manual = 1'b0;
  logic        busy_model;
  int          busy_cnt;

  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;

  logic [7:0]  log_data [$];
  logic        log_ack [$];
  int          log_cyc [$];

  uart_tx_scheduler #(.FIFO_DEPTH(16), .BUSY_TIMEOUT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .core_we      (core_we),
    .core_data    (core_data),
    .dma_req      (dma_req),
    .dma_data     (dma_data),
    .dma_ack      (dma_ack),
    .overflow_clr (overflow_clr),
    .tx_start     (tx_start),
    .sdata        (sdata),
    .tx_busy      (tx_busy),
    .free_slots   (free_slots),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  assign tx_busy = model_en ? busy_model : busy_manual;

  // UartTx stand-in: busy rises at the negedge where tx_start is seen and
  // stays high for 10 cycles.
  always @(negedge clock or posedge reset) begin
    if (reset) begin
      busy_model <= 1'b0;
      busy_cnt   <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1)
        busy_model <= 1'b0;
    end else if (model_en && tx_start === 1'b1) begin
      busy_model <= 1'b1;
      busy_cnt   <= 10;
    end
  end

  // Start-pulse monitor with cycle stamps.
  always @(negedge clock) begin
    if (tx_start === 1'b1) begin
      log_data.push_back(sdata);
      log_ack.push_back(dma_ack);
      log_cyc.push_back(ncyc);
    end
    ncyc <= ncyc + 1;
  end

  task automatic wait_log(input int n, input int limit, input string name);
    int k = 0;
    while (log_data.size() < n && k < limit) begin
      @(negedge clock);
      k++;
    end
    if (log_data.size() < n) begin
      $display("[TB] FAIL %s: timeout, got %0d starts, required %0d", name, log_data.size(), n);
      errors++;
    end
    checks++;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    if (free_slots !== 32'd16) begin $display("[TB] FAIL reset_free_slots: got %0d required 16", free_slots); errors++; end
    checks++;
    if (tx_start !== 1'b0) begin $display("[TB] FAIL reset_tx_start: got %b required 0", tx_start); errors++; end
    checks++;
    if (sdata !== 8'h00) begin $display("[TB] FAIL reset_sdata: got %h required 00", sdata); errors++; end
    checks++;
    if (overflow !== 1'b0) begin $display("[TB] FAIL reset_overflow: got %b required 0", overflow); errors++; end
    checks++;
    if (dma_ack !== 1'b0) begin $display("[TB] FAIL reset_dma_ack: got %b required 0", dma_ack); errors++; end
    checks++;
  endtask

  task automatic test_single;
    int base;
    model_en = 1'b1;
    base = log_data.size();
    @(negedge clock);
    core_we = 1'b1; core_data = 8'h41;
    @(negedge clock);
    core_we = 1'b0;
    if (free_slots !== 32'd15) begin $display("[TB] FAIL single_free15: got %0d required 15", free_slots); errors++; end
    checks++;
    if (tx_start !== 1'b0) begin $display("[TB] FAIL single_early_start: got %b required 0", tx_start); errors++; end
    checks++;
    @(negedge clock);
    if (tx_start !== 1'b1) begin $display("[TB] FAIL single_start: got %b required 1", tx_start); errors++; end
    checks++;
    if (sdata !== 8'h41) begin $display("[TB] FAIL single_sdata: got %h required 41", sdata); errors++; end
    checks++;
    if (free_slots !== 32'd16) begin $display("[TB] FAIL single_free16: got %0d required 16", free_slots); errors++; end
    checks++;
    core_we = 1'b1; core_data = 8'h42;
    @(negedge clock);
    core_we = 1'b0;
    if (tx_start !== 1'b0) begin $display("[TB] FAIL single_pulse_width: got %b required 0", tx_start); errors++; end
    checks++;
    wait_log(base + 2, 60, "single_wait");
    if (log_data.size() >= base + 2) begin
      if (log_data[base+1] !== 8'h42) begin $display("[TB] FAIL single_second_byte: got %h required 42", log_data[base+1]); errors++; end
      checks++;
      // busy falls 10 cycles after the start, then WAIT_LO->IDLE and a grant
      if (log_cyc[base+1] - log_cyc[base] != 12) begin
        $display("[TB] FAIL single_spacing: got %0d cycles required 12", log_cyc[base+1] - log_cyc[base]); errors++;
      end
      checks++;
    end
    repeat (14) @(negedge clock);
  endtask

  task automatic test_overflow;
    int base;
    model_en = 1'b0;
    busy_manual = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      if (i == 16) begin
        if (free_slots !== 32'd0) begin $display("[TB] FAIL ovf_full: got %0d required 0", free_slots); errors++; end
        checks++;
        if (overflow !== 1'b0) begin $display("[TB] FAIL ovf_not_yet: got %b required 0", overflow); errors++; end
        checks++;
      end
      core_we = 1'b1; core_data = 8'(i);
    end
    @(negedge clock);
    core_we = 1'b0;
    if (overflow !== 1'b1) begin $display("[TB] FAIL ovf_set: got %b required 1", overflow); errors++; end
    checks++;
    if (free_slots !== 32'd0) begin $display("[TB] FAIL ovf_still_full: got %0d required 0", free_slots); errors++; end
    checks++;
    if (tx_start !== 1'b0) begin $display("[TB] FAIL ovf_busy_blocks: got %b required 0", tx_start); errors++; end
    checks++;
    overflow_clr = 1'b1;
    @(negedge clock);
    overflow_clr = 1'b0;
    if (overflow !== 1'b0) begin $display("[TB] FAIL ovf_clear: got %b required 0", overflow); errors++; end
    checks++;
    core_we = 1'b1; core_data = 8'h99; overflow_clr = 1'b1;
    @(negedge clock);
    core_we = 1'b0; overflow_clr = 1'b0;
    if (overflow !== 1'b1) begin $display("[TB] FAIL ovf_set_wins: got %b required 1", overflow); errors++; end
    checks++;
    overflow_clr = 1'b1;
    @(negedge clock);
    overflow_clr = 1'b0;
    if (overflow !== 1'b0) begin $display("[TB] FAIL ovf_clear2: got %b required 0", overflow); errors++; end
    checks++;
    base = log_data.size();
    model_en = 1'b1;
    wait_log(base + 16, 400, "ovf_drain");
    for (int i = 0; i < 16; i++) begin
      if (base + i < log_data.size()) begin
        if (log_data[base+i] !== 8'(i)) begin
          $display("[TB] FAIL ovf_order[%0d]: got %h required %h", i, log_data[base+i], 8'(i)); errors++;
        end
        checks++;
      end
    end
    repeat (14) @(negedge clock);
    if (log_data.size() != base + 16) begin $display("[TB] FAIL ovf_extra_start: got %0d starts required 16", log_data.size() - base); errors++; end
    checks++;
    if (free_slots !== 32'd16) begin $display("[TB] FAIL ovf_empty: got %0d required 16", free_slots); errors++; end
    checks++;
  endtask

  task automatic test_arbitration;
    int base;
    int acks = 0;
    int k = 0;
    logic [7:0] exp_data [4];
    logic       exp_ack [4];
    exp_data[0] = 8'hD0; exp_data[1] = 8'hA0; exp_data[2] = 8'hD1; exp_data[3] = 8'hA1;
    exp_ack[0] = 1'b1; exp_ack[1] = 1'b0; exp_ack[2] = 1'b1; exp_ack[3] = 1'b0;
    model_en = 1'b0;
    busy_manual = 1'b1;
    @(negedge clock);
    core_we = 1'b1; core_data = 8'hA0;
    @(negedge clock);
    core_data = 8'hA1;
    @(negedge clock);
    core_we = 1'b0;
    dma_req = 1'b1; dma_data = 8'hD0;
    base = log_data.size();
    model_en = 1'b1;
    while (log_data.size() < base + 4 && k < 300) begin
      @(negedge clock);
      k++;
      if (dma_ack === 1'b1) begin
        acks++;
        if (acks == 1) dma_data = 8'hD1;
        else dma_req = 1'b0;
      end
    end
    dma_req = 1'b0;
    if (log_data.size() < base + 4) begin $display("[TB] FAIL arb_timeout: got %0d starts required 4", log_data.size() - base); errors++; end
    checks++;
    for (int i = 0; i < 4; i++) begin
      if (base + i < log_data.size()) begin
        if (log_data[base+i] !== exp_data[i]) begin
          $display("[TB] FAIL arb_order[%0d]: got %h required %h", i, log_data[base+i], exp_data[i]); errors++;
        end
        checks++;
        if (log_ack[base+i] !== exp_ack[i]) begin
          $display("[TB] FAIL arb_ack[%0d]: got %b required %b", i, log_ack[base+i], exp_ack[i]); errors++;
        end
        checks++;
      end
    end
    repeat (14) @(negedge clock);
  endtask

  task automatic test_timeout;
    int base;
    model_en = 1'b0;
    busy_manual = 1'b1;
    @(negedge clock);
    core_we = 1'b1; core_data = 8'hB0;
    @(negedge clock);
    core_data = 8'hB1;
    @(negedge clock);
    core_we = 1'b0;
    base = log_data.size();
    busy_manual = 1'b0;
    wait_log(base + 2, 60, "timeout_wait");
    if (log_data.size() >= base + 2) begin
      if (log_data[base] !== 8'hB0) begin $display("[TB] FAIL timeout_first: got %h required B0", log_data[base]); errors++; end
      checks++;
      if (log_data[base+1] !== 8'hB1) begin $display("[TB] FAIL timeout_second: got %h required B1", log_data[base+1]); errors++; end
      checks++;
      // LAUNCH + 4 cycles WAIT_HI + IDLE
      if (log_cyc[base+1] - log_cyc[base] != 6) begin
        $display("[TB] FAIL timeout_spacing: got %0d cycles required 6", log_cyc[base+1] - log_cyc[base]); errors++;
      end
      checks++;
    end
    repeat (10) @(negedge clock);
    if (free_slots !== 32'd16) begin $display("[TB] FAIL timeout_empty: got %0d required 16", free_slots); errors++; end
    checks++;
  endtask

  task automatic test_reset_mid;
    int base;
    model_en = 1'b0;
    busy_manual = 1'b0;
    @(negedge clock);
    core_we = 1'b1; core_data = 8'hC1;
    @(negedge clock);
    core_data = 8'hC2;
    @(negedge clock);
    core_data = 8'hC3;
    busy_manual = 1'b1;
    @(negedge clock);
    core_data = 8'hC4;
    @(negedge clock);
    core_we = 1'b0;
    @(negedge clock);
    if (free_slots !== 32'd13) begin $display("[TB] FAIL mid_queued: got %0d required 13", free_slots); errors++; end
    checks++;
    if (sdata !== 8'hC1) begin $display("[TB] FAIL mid_sdata: got %h required C1", sdata); errors++; end
    checks++;
    #2 reset = 1'b1;
    #1;
    if (tx_start !== 1'b0) begin $display("[TB] FAIL mid_rst_tx_start: got %b required 0", tx_start); errors++; end
    checks++;
    if (sdata !== 8'h00) begin $display("[TB] FAIL mid_rst_sdata: got %h required 00", sdata); errors++; end
    checks++;
    if (free_slots !== 32'd16) begin $display("[TB] FAIL mid_rst_free: got %0d required 16", free_slots); errors++; end
    checks++;
    if (dma_ack !== 1'b0) begin $display("[TB] FAIL mid_rst_dma_ack: got %b required 0", dma_ack); errors++; end
    checks++;
    if (overflow !== 1'b0) begin $display("[TB] FAIL mid_rst_overflow: got %b required 0", overflow); errors++; end
    checks++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    busy_manual = 1'b0;
    base = log_data.size();
    repeat (30) @(negedge clock);
    if (log_data.size() != base) begin $display("[TB] FAIL mid_no_start: got %0d starts required 0", log_data.size() - base); errors++; end
    checks++;
    if (free_slots !== 32'd16) begin $display("[TB] FAIL mid_after_free: got %0d required 16", free_slots); errors++; end
    checks++;
  endtask

  // Scenario sequence; each task leaves the DUT idle for the next one.
  initial begin
    $display("[TB] uart_tx_scheduler bench start");
    test_reset;
    test_single;
    test_overflow;
    test_arbitration;
    test_timeout;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
